// File: rtl/ecc_76_rd_chk.sv
// Read-side stage after the 76-bit SECDED decoder: 2-entry skid buffer, saturating error counters,
// first-error capture and sticky irq. Define ECC_POISON_EN to carry a poison bit with each word.
module ecc_76_rd_chk #(
   parameter int DATA_WIDTH = 76,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic                  in_sbit_err,
   input  logic                  in_dbit_err,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
`ifdef ECC_POISON_EN
   output logic                  out_poison,
`endif
   output logic [CNT_WIDTH-1:0]  sbit_cnt,
   output logic [CNT_WIDTH-1:0]  dbit_cnt,
   output logic                  err_vld,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic                  err_dbit,
   input  logic                  irq_en,
   output logic                  irq,
   input  logic                  clr
);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic                  wr_ptr_q, rd_ptr_q;
   logic [1:0]            cnt_q, cnt_d;
   logic                  in_rdy_q;
   logic                  push, pop;

   logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
   logic                  err_vld_q, err_vld_d, err_dbit_q, err_dbit_d;
   logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
   logic                  irq_q, irq_d;

   assign push    = in_vld & in_rdy_q;
   assign pop     = out_vld & out_rdy;
   assign out_vld = (cnt_q != 2'd0);
   assign in_rdy  = in_rdy_q;

   always_comb begin
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mem_q[gi] <= '0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
               mem_q[gi] <= in_data;
            end
         end
      end
   endgenerate

`ifdef ECC_POISON_EN
   logic poison_q [2];
   generate
      for (gi = 0; gi < 2; gi++) begin : g_poison
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               poison_q[gi] <= 1'b0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
               poison_q[gi] <= in_dbit_err;
            end
         end
      end
   endgenerate
   // Poisoned words are replaced by all ones so corrupt data is never consumed silently.
   assign out_poison = out_vld & poison_q[rd_ptr_q];
   assign out_data   = out_poison ? '1 : mem_q[rd_ptr_q];
`else
   assign out_data   = mem_q[rd_ptr_q];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         in_rdy_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         cnt_q    <= cnt_d;
         in_rdy_q <= (cnt_d != 2'd2);
      end
   end

   // clr acts first so an error accepted in the same cycle lands on the cleared state.
   always_comb begin
      sbit_cnt_d = clr ? '0 : sbit_cnt_q;
      dbit_cnt_d = clr ? '0 : dbit_cnt_q;
      err_vld_d  = clr ? 1'b0 : err_vld_q;
      err_dbit_d = clr ? 1'b0 : err_dbit_q;
      err_addr_d = clr ? '0 : err_addr_q;
      if (push && in_dbit_err && (dbit_cnt_d != '1)) begin
         dbit_cnt_d = dbit_cnt_d + 1'b1;
      end
      if (push && in_sbit_err && !in_dbit_err && (sbit_cnt_d != '1)) begin
         sbit_cnt_d = sbit_cnt_d + 1'b1;
      end
      if (push && (in_sbit_err || in_dbit_err) &&
          (!err_vld_d || (!err_dbit_d && in_dbit_err))) begin
         err_vld_d  = 1'b1;
         err_dbit_d = in_dbit_err;
         err_addr_d = in_addr;
      end
      irq_d = clr ? 1'b0 : (err_vld_q & irq_en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbit_cnt_q <= '0;
         dbit_cnt_q <= '0;
         err_vld_q  <= 1'b0;
         err_dbit_q <= 1'b0;
         err_addr_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sbit_cnt_q <= sbit_cnt_d;
         dbit_cnt_q <= dbit_cnt_d;
         err_vld_q  <= err_vld_d;
         err_dbit_q <= err_dbit_d;
         err_addr_q <= err_addr_d;
         irq_q      <= irq_d;
      end
   end

   assign sbit_cnt = sbit_cnt_q;
   assign dbit_cnt = dbit_cnt_q;
   assign err_vld  = err_vld_q;
   assign err_dbit = err_dbit_q;
   assign err_addr = err_addr_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_ecc_76_rd_chk.sv
// Scoreboard bench for ecc_76_rd_chk: expected words queued on accept, compared on pop.
module tb_ecc_76_rd_chk;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [75:0] in_data = '0;
   logic [7:0]  in_addr = '0;
   logic        in_sbit_err = 1'b0;
   logic        in_dbit_err = 1'b0;
   logic        out_vld;
   logic        out_rdy = 1'b0;
   logic [75:0] out_data;
   logic [15:0] sbit_cnt, dbit_cnt;
   logic        err_vld;
   logic [7:0]  err_addr;
   logic        err_dbit;
   logic        irq_en = 1'b0;
   logic        irq;
   logic        clr = 1'b0;
`ifdef ECC_POISON_EN
   logic        out_poison;
`endif

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [75:0] data;
      logic        poison;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   ecc_76_rd_chk dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_addr(in_addr),
      .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
`ifdef ECC_POISON_EN
      .out_poison(out_poison),
`endif
      .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
      .err_vld(err_vld), .err_addr(err_addr), .err_dbit(err_dbit),
      .irq_en(irq_en), .irq(irq), .clr(clr)
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [75:0] d, input logic [7:0] a, input logic s, input logic db);
      int t;
      in_vld = 1'b1; in_data = d; in_addr = a; in_sbit_err = s; in_dbit_err = db;
      t = 0;
      @(negedge clk);
      while (!in_rdy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_rdy) chk("accept_timeout", 96'd0, 96'd1);
      step();
      in_vld = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", 96'(sb.size()), 96'd0);
      step();
   endtask

   // Monitor: sample between edges while inputs are stable.
   always @(negedge clk) begin
      exp_t e, g;
      if (!rst) begin
         if (in_vld && in_rdy) begin
`ifdef ECC_POISON_EN
            e.data   = in_dbit_err ? {76{1'b1}} : in_data;
            e.poison = in_dbit_err;
`else
            e.data   = in_data;
            e.poison = 1'b0;
`endif
            sb.push_back(e);
         end
         if (out_vld && out_rdy) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_word", 96'(out_data), 96'd0);
               if (out_data === 76'd0) chk("sb_unexpected_pop", 96'd1, 96'd0);
            end else begin
               g = sb.pop_front();
               chk("sb_data", 96'(out_data), 96'(g.data));
`ifdef ECC_POISON_EN
               chk("sb_poison", 96'(out_poison), 96'(g.poison));
`endif
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_vld", 96'(out_vld), 96'd0);
      chk("rst_in_rdy", 96'(in_rdy), 96'd0);
      chk("rst_sbit_cnt", 96'(sbit_cnt), 96'd0);
      chk("rst_err_vld", 96'(err_vld), 96'd0);
      step();
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("post_rst_in_rdy", 96'(in_rdy), 96'd1);
      step();

      // Clean words, one-cycle latency
      out_rdy = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         send(76'(i), 8'(i), 1'b0, 1'b0);
         @(negedge clk);
         chk("lat_out_vld", 96'(out_vld), 96'd1);
         chk("lat_out_data", 96'(out_data), 96'(i));
         step();
      end
      chk("clean_sbit_cnt", 96'(sbit_cnt), 96'd0);
      chk("clean_dbit_cnt", 96'(dbit_cnt), 96'd0);
      chk("clean_err_vld", 96'(err_vld), 96'd0);

      // Backpressure: buffer fills, third word held
      out_rdy = 1'b0;
      send(76'hA, 8'h1, 1'b0, 1'b0);
      send(76'hB, 8'h2, 1'b0, 1'b0);
      @(negedge clk);
      chk("full_in_rdy", 96'(in_rdy), 96'd0);
      step();
      in_vld = 1'b1; in_data = 76'hC;
      repeat (3) begin
         @(negedge clk);
         chk("held_in_rdy", 96'(in_rdy), 96'd0);
         chk("stable_out_data", 96'(out_data), 96'hA);
      end
      step();
      out_rdy = 1'b1;
      send(76'hC, 8'h3, 1'b0, 1'b0);
      drain();

      // Error counting, capture and irq
      irq_en = 1'b1;
      send(76'h10, 8'h10, 1'b1, 1'b0);
      @(negedge clk);
      chk("cap_err_vld", 96'(err_vld), 96'd1);
      chk("irq_delay0", 96'(irq), 96'd0);
      step();
      @(negedge clk);
      chk("irq_delay1", 96'(irq), 96'd1);
      step();
      send(76'h20, 8'h20, 1'b0, 1'b1);
      send(76'h30, 8'h30, 1'b1, 1'b0);
      drain();
      chk("mix_sbit_cnt", 96'(sbit_cnt), 96'd2);
      chk("mix_dbit_cnt", 96'(dbit_cnt), 96'd1);
      chk("mix_err_addr", 96'(err_addr), 96'h20);
      chk("mix_err_dbit", 96'(err_dbit), 96'd1);

      // Plain clear
      clr = 1'b1;
      step();
      clr = 1'b0;
      @(negedge clk);
      chk("clr_sbit_cnt", 96'(sbit_cnt), 96'd0);
      chk("clr_dbit_cnt", 96'(dbit_cnt), 96'd0);
      chk("clr_err_vld", 96'(err_vld), 96'd0);
      chk("clr_irq", 96'(irq), 96'd0);
      step();

      // clr coincident with an accepted sbit word
      clr = 1'b1;
      send(76'h44, 8'h44, 1'b1, 1'b0);
      clr = 1'b0;
      @(negedge clk);
      chk("clrsim_sbit_cnt", 96'(sbit_cnt), 96'd1);
      chk("clrsim_dbit_cnt", 96'(dbit_cnt), 96'd0);
      chk("clrsim_err_addr", 96'(err_addr), 96'h44);
      chk("clrsim_err_vld", 96'(err_vld), 96'd1);
      chk("clrsim_err_dbit", 96'(err_dbit), 96'd0);
      step();

      // Both flags: only dbit counts; dbit overrides sbit capture
      send(76'h55, 8'h55, 1'b1, 1'b1);
      @(negedge clk);
      chk("both_sbit_cnt", 96'(sbit_cnt), 96'd1);
      chk("both_dbit_cnt", 96'(dbit_cnt), 96'd1);
      chk("both_err_addr", 96'(err_addr), 96'h55);
      chk("both_err_dbit", 96'(err_dbit), 96'd1);
      step();
      drain();

`ifdef ECC_POISON_EN
      send(76'h5, 8'h60, 1'b0, 1'b1);
      @(negedge clk);
      chk("poison_flag", 96'(out_poison), 96'd1);
      chk("poison_data", 96'(out_data), 96'({76{1'b1}}));
      step();
      send(76'h6, 8'h61, 1'b0, 1'b0);
      @(negedge clk);
      chk("clean_poison", 96'(out_poison), 96'd0);
      chk("clean_data", 96'(out_data), 96'h6);
      step();
      drain();
`endif

      // Saturation
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int i = 0; i < 65535; i++) begin
         send(76'(i), 8'(i), 1'b1, 1'b0);
      end
      @(negedge clk);
      chk("sat_reach_max", 96'(sbit_cnt), 96'hFFFF);
      step();
      send(76'h77, 8'h77, 1'b1, 1'b0);
      @(negedge clk);
      chk("sat_hold_max", 96'(sbit_cnt), 96'hFFFF);
      chk("sat_dbit_cnt", 96'(dbit_cnt), 96'd0);
      step();
      drain();

      // Asynchronous reset mid-transfer
      out_rdy = 1'b0;
      send(76'h99, 8'h99, 1'b0, 1'b0);
      @(negedge clk);
      chk("pre_rst_out_vld", 96'(out_vld), 96'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_vld", 96'(out_vld), 96'd0);
      chk("async_rst_sbit_cnt", 96'(sbit_cnt), 96'd0);
      sb.delete();
      step();
      step();
      rst = 1'b0;
      out_rdy = 1'b1;
      step();
      @(negedge clk);
      chk("rerst_in_rdy", 96'(in_rdy), 96'd1);
      chk("rerst_out_vld", 96'(out_vld), 96'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
